// File: rtl/flit_pkg.sv
// Shared flit definitions: type encoding, type-field geometry, framing states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package flit_pkg;

    // Width of the type field at the top of every flit.
    localparam int FLIT_TYPE_W = 2;

    // Default link flit width (type field plus 32-bit payload).
    localparam int FLIT_WIDTH_DEFAULT = 34;

    // Flit type encoding carried in the top FLIT_TYPE_W bits.
    typedef enum logic [FLIT_TYPE_W-1:0] {
        HEAD_TAIL = 2'b00,
        HEAD      = 2'b01,
        BODY      = 2'b10,
        TAIL      = 2'b11
    } flit_type_t;

    // Packet framing tracker: outside a packet, or between HEAD and TAIL.
    typedef enum logic {
        FRAME_IDLE   = 1'b0,
        FRAME_IN_PKT = 1'b1
    } frame_state_t;

    // MSB index of the type field for a given flit width.
    function automatic int type_msb(input int flit_width);
        return flit_width - 1;
    endfunction

endpackage

// File: rtl/flit_credit_tx_credit_counter.sv
// Remote-buffer credit counter: decrement per sent flit, increment per returned credit.
// Latency: count and overflow flag are registered, visible the cycle after dec/inc.
// Backpressure: none; zero_o tells the sender to stop, surplus credits raise ovf_o.
module credit_counter #(
    parameter int CREDITS = 2
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     dec_i,
    input  logic                     inc_i,
    output logic [$clog2(CREDITS):0] cnt_o,
    output logic                     zero_o,
    output logic                     ovf_o
);

    localparam int              CW      = $clog2(CREDITS) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CREDITS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ovf_q;
    logic          ovf_d;

    // Next count: dec and inc together cancel; a credit beyond the maximum is
    // discarded and flagged instead of wrapping the count.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count and overflow pulse registers; reset refills to the full remote depth.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q <= CNT_MAX;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/flit_credit_tx.sv
// Drains the router output fifo onto a credit-based link, checking packet framing.
// Latency: 1 cycle from fifo pop to flit_valid_o; 1 flit/cycle while credits remain.
// Backpressure: pops only when fifo non-empty and credits > 0; credit_i frees a slot next cycle.
module flit_credit_tx
    import flit_pkg::*;
#(
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEFAULT,
    parameter int CREDITS    = 2
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [FLIT_WIDTH-1:0]    fifo_data_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_read_o,
    output logic [FLIT_WIDTH-1:0]    flit_o,
    output logic                     flit_valid_o,
    input  logic                     credit_i,
    output logic [$clog2(CREDITS):0] credits_o,
    output logic                     proto_err_o,
    output logic                     credit_err_o
);

    localparam int TYPE_MSB = type_msb(FLIT_WIDTH);

    logic                  fire;
    logic                  credits_zero;
    flit_type_t            head_type;
    frame_state_t          state_q;
    frame_state_t          state_d;
    logic                  frame_err;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  flit_vld_q;
    logic                  proto_err_q;

    // Credits are tracked from registered state only, so a returning credit
    // never reaches fifo_read_o combinationally.
    credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit_counter (
        .clk    (clk),
        .arst_n (arst_n),
        .dec_i  (fire),
        .inc_i  (credit_i),
        .cnt_o  (credits_o),
        .zero_o (credits_zero),
        .ovf_o  (credit_err_o)
    );

    assign fire        = arst_n && !fifo_empty_i && !credits_zero;
    assign fifo_read_o = fire;
    assign head_type   = flit_type_t'(fifo_data_i[TYPE_MSB -: FLIT_TYPE_W]);

    // Framing state register; only popped flits advance it.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= FRAME_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Framing next-state and violation detect; an out-of-place HEAD/HEAD_TAIL
    // restarts a packet rather than being dropped.
    always_comb begin
        state_d   = state_q;
        frame_err = 1'b0;
        if (fire) begin
            case (state_q)
                FRAME_IDLE: begin
                    case (head_type)
                        HEAD:      state_d = FRAME_IN_PKT;
                        HEAD_TAIL: state_d = FRAME_IDLE;
                        default: begin
                            state_d   = FRAME_IDLE;
                            frame_err = 1'b1;
                        end
                    endcase
                end
                default: begin
                    case (head_type)
                        BODY:      state_d = FRAME_IN_PKT;
                        TAIL:      state_d = FRAME_IDLE;
                        HEAD: begin
                            state_d   = FRAME_IN_PKT;
                            frame_err = 1'b1;
                        end
                        default: begin
                            state_d   = FRAME_IDLE;
                            frame_err = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

    // Link output register: capture the popped flit, pulse valid, align the
    // framing error with the offending flit; flit_o holds when idle.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            flit_q      <= '0;
            flit_vld_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            flit_vld_q  <= fire;
            proto_err_q <= frame_err;
            if (fire) begin
                flit_q <= fifo_data_i;
            end
        end
    end

    assign flit_o       = flit_q;
    assign flit_valid_o = flit_vld_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_flit_credit_tx.sv
// Self-checking bench for flit_credit_tx: directed table, corner sequences, random traffic.
// Latency: checks pop strobe before each edge and registered outputs 1 time unit after.
// Backpressure: fifo modelled as a queue; credit returns driven by the bench.
module tb_flit_credit_tx;
    import flit_pkg::*;

    localparam int FW = 34;
    localparam int CR = 2;
    localparam int CW = $clog2(CR) + 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [FW-1:0] fifo_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_read_o;
    logic [FW-1:0] flit_o;
    logic          flit_valid_o;
    logic          credit_i = 1'b0;
    logic [CW-1:0] credits_o;
    logic          proto_err_o;
    logic          credit_err_o;

    always #5 clk = ~clk;

    flit_credit_tx #(
        .FLIT_WIDTH (FW),
        .CREDITS    (CR)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_read_o  (fifo_read_o),
        .flit_o       (flit_o),
        .flit_valid_o (flit_valid_o),
        .credit_i     (credit_i),
        .credits_o    (credits_o),
        .proto_err_o  (proto_err_o),
        .credit_err_o (credit_err_o)
    );

    int errors = 0;
    int checks = 0;

    // Upstream fifo contents, head at index 0.
    logic [FW-1:0] q[$];

    // Reference model state.
    int            m_cred = CR;
    bit            m_in_pkt = 1'b0;
    bit            m_vld = 1'b0;
    bit            m_perr = 1'b0;
    bit            m_cerr = 1'b0;
    logic [FW-1:0] m_flit = '0;
    bit            m_fire = 1'b0;
    bit            rd_seen = 1'b0;

    typedef struct {
        bit rst_n;
        bit cred;
        bit e_rd;
        bit e_vld;
        int e_cred;
        bit e_perr;
        bit e_cerr;
    } vec_t;

    vec_t tbl[12];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] t, input logic [31:0] p);
        logic [FW-1:0] f;
        f = '0;
        f[FW-1 -: 2] = t;
        f[FW-3:0]    = p;
        return f;
    endfunction

    // One clock cycle: drive inputs, check the pop strobe, step the model, check outputs.
    task automatic cycle(input bit rst_n_v, input bit cred_v);
        logic [FW-1:0] h;
        logic [1:0]    t;
        bit            starts;
        arst_n       = rst_n_v;
        credit_i     = cred_v;
        fifo_empty_i = (q.size() == 0);
        fifo_data_i  = (q.size() != 0) ? q[0] : '0;
        #1;
        m_fire  = rst_n_v && (q.size() != 0) && (m_cred > 0);
        rd_seen = fifo_read_o;
        chk("fifo_read_o", fifo_read_o, m_fire);
        @(posedge clk);
        if (!rst_n_v) begin
            m_cred   = CR;
            m_in_pkt = 1'b0;
            m_vld    = 1'b0;
            m_perr   = 1'b0;
            m_cerr   = 1'b0;
            m_flit   = '0;
        end else begin
            m_vld  = m_fire;
            m_perr = 1'b0;
            m_cerr = cred_v && !m_fire && (m_cred == CR);
            if (m_fire) begin
                h      = q.pop_front();
                t      = h[FW-1 -: 2];
                m_flit = h;
                starts = (t == 2'(HEAD)) || (t == 2'(HEAD_TAIL));
                // A start type inside a packet, or a continuation outside one, is a violation.
                m_perr = (starts && m_in_pkt) || (!starts && !m_in_pkt);
                m_in_pkt = (t == 2'(HEAD)) || ((t == 2'(BODY)) && m_in_pkt);
            end
            m_cred = m_cred - int'(m_fire) + int'(cred_v);
            if (m_cred > CR) m_cred = CR;
        end
        #1;
        chk("flit_valid_o", flit_valid_o, m_vld);
        chk("flit_o", flit_o, m_flit);
        chk("credits_o", credits_o, m_cred);
        chk("proto_err_o", proto_err_o, m_perr);
        chk("credit_err_o", credit_err_o, m_cerr);
        @(negedge clk);
    endtask

    initial begin
        // Directed table: reset, HEAD/BODY/TAIL with two credits, then credit overflow.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};

        @(negedge clk);
        q.push_back(mk_flit(2'b01, 32'hA000_0001));
        q.push_back(mk_flit(2'b10, 32'hA000_0002));
        q.push_back(mk_flit(2'b11, 32'hA000_0003));
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst_n, tbl[i].cred);
            chk($sformatf("tbl%0d_rd", i), rd_seen, tbl[i].e_rd);
            chk($sformatf("tbl%0d_vld", i), flit_valid_o, tbl[i].e_vld);
            chk($sformatf("tbl%0d_cred", i), credits_o, tbl[i].e_cred);
            chk($sformatf("tbl%0d_perr", i), proto_err_o, tbl[i].e_perr);
            chk($sformatf("tbl%0d_cerr", i), credit_err_o, tbl[i].e_cerr);
        end

        // Sustained traffic with a credit returned every cycle.
        q.push_back(mk_flit(2'b01, 32'hB000_0000));
        for (int i = 1; i <= 6; i++) q.push_back(mk_flit(2'b10, 32'hB000_0000 + 32'(i)));
        q.push_back(mk_flit(2'b11, 32'hB000_00FF));
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1);
            chk("sustain_vld", flit_valid_o, 1'b1);
            chk("sustain_cred_range", (credits_o == 1) || (credits_o == 2), 1'b1);
            chk("sustain_cerr", credit_err_o, 1'b0);
        end
        cycle(1'b1, 1'b0);
        chk("sustain_drained_vld", flit_valid_o, 1'b0);

        // BODY while idle, then HEAD, HEAD: errors on the 1st and 3rd flits.
        q.push_back(mk_flit(2'b10, 32'hC000_0001));
        q.push_back(mk_flit(2'b01, 32'hC000_0002));
        q.push_back(mk_flit(2'b01, 32'hC000_0003));
        cycle(1'b1, 1'b1);
        chk("frame1_vld", flit_valid_o, 1'b1);
        chk("frame1_perr", proto_err_o, 1'b1);
        cycle(1'b1, 1'b1);
        chk("frame2_perr", proto_err_o, 1'b0);
        chk("frame2_flit", flit_o, mk_flit(2'b01, 32'hC000_0002));
        cycle(1'b1, 1'b1);
        chk("frame3_vld", flit_valid_o, 1'b1);
        chk("frame3_perr", proto_err_o, 1'b1);
        q.push_back(mk_flit(2'b11, 32'hC000_0004));
        cycle(1'b1, 1'b1);
        chk("frame_tail_perr", proto_err_o, 1'b0);

        // Reset right after a HEAD: credits refill, FSM back to idle.
        q.push_back(mk_flit(2'b01, 32'hD000_0001));
        cycle(1'b1, 1'b0);
        chk("rst_pre_cred", credits_o, 1);
        q.push_back(mk_flit(2'b10, 32'hD000_0002));
        cycle(1'b0, 1'b0);
        chk("rst_rd", rd_seen, 1'b0);
        chk("rst_cred", credits_o, 2);
        chk("rst_vld", flit_valid_o, 1'b0);
        cycle(1'b1, 1'b0);
        chk("rst_body_vld", flit_valid_o, 1'b1);
        chk("rst_body_perr", proto_err_o, 1'b1);
        cycle(1'b1, 1'b1);

        // Random traffic, credit returns and occasional resets against the model.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 3) != 0) && (q.size() < 8))
                q.push_back(mk_flit(2'($urandom_range(0, 3)), $urandom));
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
